// File: rtl/mon_enc_pkg.sv
// mon_enc_pkg: shared types for the monitor symbol encoder (state enum, symbol type).
`default_nettype none

package mon_enc_pkg;

  localparam int SYM_W = 8;

  typedef logic [SYM_W-1:0] mon_sym_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MRST   = 2'd1,
    STREAM = 2'd2
  } mon_enc_state_e;

endpackage

`default_nettype wire

// File: rtl/mon_enc_fifo.sv
// mon_enc_fifo: synchronous FIFO with flush; pointers carry an extra wrap bit for full/empty.
`default_nettype none

module mon_enc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/monitor_symbol_encoder.sv
// monitor_symbol_encoder: packs trace propositions into symbols and sequences the LTL monitor.
// Optional MON_ENC_DEDUP_EN drops repeated symbols and counts them on dedup_count.
`default_nettype none

module monitor_symbol_encoder
  import mon_enc_pkg::*;
#(
  parameter int NUM_PROPS  = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trace_start,
  input  logic                          evt_valid,
  input  logic [NUM_PROPS-1:0]          evt_props,
  output logic                          evt_ready,
  input  logic                          mon_stall,
  output logic                          mon_reset,
  output logic                          mon_run,
  output logic [SYM_W-1:0]              mon_symbols,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef MON_ENC_DEDUP_EN
  ,
  output logic [15:0]                   dedup_count
`endif
);

  localparam int CNT_W = $clog2(RST_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

  mon_enc_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  mon_sym_t         sym_q;

  mon_sym_t evt_sym;
  logic     fifo_full;
  logic     fifo_empty;
  mon_sym_t fifo_rdata;
  logic     accept;
  logic     push;
  logic     pop;
  logic     flush;

  assign evt_sym = mon_sym_t'(evt_props);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trace_start) begin
          state_d = MRST;
          cnt_d   = CNT_LOAD;
        end
      end
      MRST: begin
        if (trace_start) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STREAM: begin
        if (trace_start) begin
          state_d = MRST;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A trace_start in STREAM discards the queue in the same cycle, so nothing is popped.
  assign evt_ready = (state_q == STREAM) && !fifo_full && !trace_start;
  assign accept    = evt_valid && evt_ready;
  assign pop       = (state_q == STREAM) && !fifo_empty && !mon_stall && !trace_start;
  assign flush     = trace_start || (state_q == MRST);
  assign mon_reset = (state_q == MRST);

`ifdef MON_ENC_DEDUP_EN
  logic       last_vld_q;
  mon_sym_t   last_sym_q;
  logic [15:0] dedup_q;
  logic       is_dup;

  assign is_dup = last_vld_q && (evt_sym == last_sym_q);
  assign push   = accept && !is_dup;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      last_vld_q <= 1'b0;
      last_sym_q <= '0;
    end else if (push) begin
      last_vld_q <= 1'b1;
      last_sym_q <= evt_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || trace_start) begin
      dedup_q <= '0;
    end else if (accept && is_dup && (dedup_q != 16'hFFFF)) begin
      dedup_q <= dedup_q + 16'd1;
    end
  end

  assign dedup_count = dedup_q;
`else
  assign push = accept;
`endif

  mon_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (evt_sym),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      sym_q <= '0;
    end else begin
      run_q <= pop;
      if (pop) sym_q <= fifo_rdata;
    end
  end

  assign mon_run     = run_q;
  assign mon_symbols = sym_q;

endmodule

`default_nettype wire

// File: tb/tb_monitor_symbol_encoder.sv
// tb_monitor_symbol_encoder: directed and randomized checks against a queue-based reference model.
`default_nettype none

module tb_monitor_symbol_encoder;

  localparam int NP    = 7;
  localparam int DEPTH = 8;
  localparam int RSTC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       trace_start;
  logic       evt_valid;
  logic [6:0] evt_props;
  logic       evt_ready;
  logic       mon_stall;
  logic       mon_reset;
  logic       mon_run;
  logic [7:0] mon_symbols;
  logic [3:0] fifo_level;
`ifdef MON_ENC_DEDUP_EN
  logic [15:0] dedup_count;
`endif

  monitor_symbol_encoder #(
    .NUM_PROPS  (NP),
    .FIFO_DEPTH (DEPTH),
    .RST_CYCLES (RSTC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_start (trace_start),
    .evt_valid   (evt_valid),
    .evt_props   (evt_props),
    .evt_ready   (evt_ready),
    .mon_stall   (mon_stall),
    .mon_reset   (mon_reset),
    .mon_run     (mon_run),
    .mon_symbols (mon_symbols),
    .fifo_level  (fifo_level)
`ifdef MON_ENC_DEDUP_EN
    ,
    .dedup_count (dedup_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a trace is either idle, in its monitor-reset window
  // (m_rl cycles still to go), or streaming; the buffer is a plain queue.
  bit         m_strm;
  int         m_rl;
  logic [7:0] m_q[$];
  bit         m_run;
  logic [7:0] m_sym;
  bit         m_lv;
  logic [7:0] m_last;
  int         m_dd;

  logic [7:0] emitted[$];
  int         n_rst_seen;
  int         n_run_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_strm = 0; m_rl = 0; m_run = 0; m_sym = 8'h00;
    m_lv = 0; m_last = 8'h00; m_dd = 0;
  endtask

  task automatic model_step(input bit rs, input bit ts, input bit v,
                            input logic [6:0] p, input bit st);
    bit rdy, acc, pop;
    logic [7:0] s;
    if (rs) begin
      model_reset();
      return;
    end
    rdy = m_strm && (m_q.size() < DEPTH) && !ts;
    acc = v && rdy;
    pop = m_strm && (m_q.size() > 0) && !st && !ts;
    m_run = pop;
    if (pop) m_sym = m_q[0];
    s = {1'b0, p};
    if (ts) begin
      m_q.delete();
      m_rl = RSTC; m_strm = 0; m_lv = 0; m_dd = 0;
    end else if (m_rl > 0) begin
      m_rl--;
      if (m_rl == 0) m_strm = 1;
    end else if (m_strm) begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
`ifdef MON_ENC_DEDUP_EN
        if (m_lv && s == m_last) begin
          if (m_dd != 32'hFFFF) m_dd++;
        end else begin
          m_q.push_back(s); m_last = s; m_lv = 1;
        end
`else
        m_q.push_back(s);
`endif
      end
    end
  endtask

  // One clock: drive inputs, compare the DUT against the model, advance the model.
  task automatic cyc(input bit rs, input bit ts, input bit v,
                     input logic [6:0] p, input bit st);
    bit rdy;
    @(negedge clk);
    reset = rs; trace_start = ts; evt_valid = v; evt_props = p; mon_stall = st;
    #1;
    rdy = m_strm && (m_q.size() < DEPTH) && !ts;
    chk("mon_reset",   {31'd0, mon_reset}, {31'd0, (m_rl > 0)});
    chk("mon_run",     {31'd0, mon_run},   {31'd0, m_run});
    chk("mon_symbols", {24'd0, mon_symbols}, {24'd0, m_sym});
    chk("evt_ready",   {31'd0, evt_ready}, {31'd0, rdy});
    chk("fifo_level",  {28'd0, fifo_level}, m_q.size());
`ifdef MON_ENC_DEDUP_EN
    chk("dedup_count", {16'd0, dedup_count}, m_dd);
`endif
    if (mon_reset === 1'b1) n_rst_seen++;
    if (mon_run === 1'b1) begin
      n_run_seen++;
      emitted.push_back(mon_symbols);
    end
    model_step(rs, ts, v, p, st);
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 7'h00, st);
  endtask

  task automatic start_trace();
    cyc(0, 1, 0, 7'h00, 0);
    idle(RSTC, 0);
  endtask

  initial begin
    reset = 1'b1; trace_start = 1'b0; evt_valid = 1'b0; evt_props = '0; mon_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values
    idle(2, 0);

    // Trace start: mon_reset for exactly RSTC cycles, then ready with no run
    n_rst_seen = 0; n_run_seen = 0;
    cyc(0, 1, 0, 7'h00, 0);
    idle(RSTC + 2, 0);
    chk("mrst_len", n_rst_seen, RSTC);
    chk("mrst_no_run", n_run_seen, 0);

    // Single-symbol latency
    emitted.delete(); n_run_seen = 0;
    cyc(0, 0, 1, 7'h2A, 0);
    cyc(0, 0, 0, 7'h00, 0);
    chk("lat_early", {31'd0, mon_run}, 32'd0);
    cyc(0, 0, 0, 7'h00, 0);
    chk("lat_run", {31'd0, mon_run}, 32'd1);
    chk("lat_sym", {24'd0, mon_symbols}, 32'h2A);
    idle(2, 0);
    chk("lat_once", n_run_seen, 1);

    // Stall: 9 offers, 8 accepted, then drain in order
    emitted.delete();
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 7'(8'h10 + i), 1);
    cyc(0, 0, 1, 7'h7F, 1);
    chk("full_level", {28'd0, fifo_level}, 32'd8);
    chk("full_ready", {31'd0, evt_ready}, 32'd0);
    idle(11, 0);
    chk("drain_cnt", emitted.size(), 8);
    for (int i = 0; i < 8 && i < emitted.size(); i++)
      chk("drain_sym", {24'd0, emitted[i]}, 32'h10 + i);

    // trace_start with 3 queued and a simultaneous event
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 7'(8'h40 + i), 1);
    n_run_seen = 0; n_rst_seen = 0;
    cyc(0, 1, 1, 7'h55, 0);
    chk("ts_ready", {31'd0, evt_ready}, 32'd0);
    cyc(0, 0, 0, 7'h00, 0);
    chk("ts_flush", {28'd0, fifo_level}, 32'd0);
    idle(RSTC, 0);
    chk("ts_no_run", n_run_seen, 0);

    // Repeated symbols
    emitted.delete();
    cyc(0, 0, 1, 7'h05, 0);
    cyc(0, 0, 1, 7'h05, 0);
    cyc(0, 0, 1, 7'h05, 0);
    cyc(0, 0, 1, 7'h06, 0);
    idle(4, 0);
`ifdef MON_ENC_DEDUP_EN
    chk("dedup_emits", emitted.size(), 2);
    chk("dedup_count_val", {16'd0, dedup_count}, 32'd2);
    if (emitted.size() == 2) chk("dedup_second", {24'd0, emitted[1]}, 32'h06);
`else
    chk("nodedup_emits", emitted.size(), 4);
    if (emitted.size() == 4) chk("nodedup_last", {24'd0, emitted[3]}, 32'h06);
`endif

    // Reset during a stalled stream
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 7'(8'h20 + i), 1);
    cyc(1, 0, 0, 7'h00, 1);
    n_run_seen = 0;
    idle(6, 0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_symbols", {24'd0, mon_symbols}, 32'd0);
    chk("rst_mon_reset", {31'd0, mon_reset}, 32'd0);
    chk("rst_no_run", n_run_seen, 0);

    // Randomized traffic
    start_trace();
    for (int i = 0; i < 600; i++) begin
      bit rs, ts, v, st;
      logic [6:0] p;
      rs = ($urandom_range(0, 199) == 0);
      ts = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 3)) : 7'($urandom);
      cyc(rs, ts, v, p, st);
    end
    idle(12, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
